// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 32-bit processor control path:
//   - state_t      : sequencer states (RST, T0..T5, HALT)
//   - OP_*         : legal register-register ALU opcodes
//   - IR_*_MSB/LSB : instruction register field bit positions
//   - is_legal_op  : opcode legality helper
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [2:0] {
        RST  = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        T5   = 3'd6,
        HALT = 3'd7
    } state_t;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b01001;
    localparam logic [4:0] OP_OR  = 5'b01010;

    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;

    function automatic logic is_legal_op(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Combinational IR decoder for the control sequencer. Extracts the opcode,
// flags whether it is one of the supported register-register ALU operations,
// and produces the ALU operation code (0 for an illegal opcode).
//
// Parameters:
//   OPW    opcode field width (IR[31:27])
//   RW     register-select field width
// Ports:
//   IR      in   32    instruction register contents
//   legal   out  1     opcode is add/sub/and/or
//   alu_op  out  OPW   opcode when legal, else 0
// -----------------------------------------------------------------------------
module ctrl_decode
    import cpu_pkg::*;
#(
    parameter int OPW = 5,
    parameter int RW  = 4
) (
    input  logic [31:0]    IR,
    output logic           legal,
    output logic [OPW-1:0] alu_op
);

    logic [OPW-1:0] opcode;
    logic [RW-1:0]  ra;
    logic [RW-1:0]  rb;
    logic [RW-1:0]  rc;
    logic           unused_fields;

    assign opcode = IR[IR_OP_LSB +: OPW];

    // Register fields are decoded by the datapath's select-and-encode logic;
    // they are sliced here only to pin down the IR layout alongside the opcode.
    assign ra = IR[IR_RA_LSB +: RW];
    assign rb = IR[IR_RB_LSB +: RW];
    assign rc = IR[IR_RC_LSB +: RW];
    assign unused_fields = ^{ra, rb, rc, IR[IR_RC_LSB-1:0]};

    assign legal  = is_legal_op(5'(opcode));
    assign alu_op = legal ? opcode : '0;

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Hardwired control unit for the 32-bit datapath. Steps through
// T0 (fetch address) -> T1 (memory read) -> T2 (IR load) -> T3 (Rb to Y)
// -> T4 (Y op Rc to Z) -> T5 (Z to Ra), then repeats or halts.
// Strobes are Moore-decoded from the registered state (and IR in T3..T5).
//
// Build option:
//   CTRL_MEM_WAIT_EN  when defined, T1 holds until Mem_ready=1 and PCin is
//                     asserted only in the final T1 cycle. When undefined,
//                     T1 lasts one cycle and Mem_ready is ignored.
//
// Parameters:
//   OPW  opcode field width, RW  register-select field width
// Ports:
//   Clock      in   1    system clock, rising edge
//   Reset      in   1    asynchronous, active-high
//   IR         in   32   instruction register from the datapath
//   Mem_ready  in   1    memory read data valid (CTRL_MEM_WAIT_EN only)
//   Stop       in   1    halt request, sampled in T5
//   PCout, Zlowout, MDRout                  out  bus drive strobes
//   MARin, Zin, PCin, MDRin, IRin, Yin      out  register load strobes
//   IncPC, Read                             out  PC increment, memory read
//   Gra, Grb, Grc                           out  IR register-field selects
//   Rin, Rout                               out  general register load/drive
//   ALU_op     out  OPW  opcode while Zin is high in T4, else 0
//   Run        out  1    high while sequencing
// -----------------------------------------------------------------------------
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int OPW = 5,
    parameter int RW  = 4
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [31:0]    IR,
    input  logic           Mem_ready,
    input  logic           Stop,
    output logic           PCout,
    output logic           Zlowout,
    output logic           MDRout,
    output logic           MARin,
    output logic           Zin,
    output logic           PCin,
    output logic           MDRin,
    output logic           IRin,
    output logic           Yin,
    output logic           IncPC,
    output logic           Read,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic [OPW-1:0] ALU_op,
    output logic           Run
);

    state_t         state;
    state_t         state_nxt;
    logic           op_legal;
    logic [OPW-1:0] dec_alu_op;
    logic           t1_done;

    ctrl_decode #(
        .OPW (OPW),
        .RW  (RW)
    ) u_decode (
        .IR     (IR),
        .legal  (op_legal),
        .alu_op (dec_alu_op)
    );

`ifdef CTRL_MEM_WAIT_EN
    // T1 is stretched until memory reports valid read data.
    assign t1_done = Mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = Mem_ready;
    assign t1_done          = 1'b1;
`endif

    // Reset clears the state asynchronously; since every strobe decodes to 0
    // in RST, the outputs drop without waiting for a clock edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        MDRout    = 1'b0;
        MARin     = 1'b0;
        Zin       = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        Rin       = 1'b0;
        Rout      = 1'b0;
        ALU_op    = '0;
        Run       = 1'b0;

        case (state)
            RST: begin
                state_nxt = T0;
            end
            T0: begin
                PCout     = 1'b1;
                MARin     = 1'b1;
                IncPC     = 1'b1;
                Zin       = 1'b1;
                Run       = 1'b1;
                state_nxt = T1;
            end
            T1: begin
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                Run     = 1'b1;
                // PC loads only on the cycle that leaves T1, so a stalled
                // fetch never loads the incremented PC more than once.
                PCin    = t1_done;
                if (t1_done) begin
                    state_nxt = T2;
                end
            end
            T2: begin
                MDRout    = 1'b1;
                IRin      = 1'b1;
                Run       = 1'b1;
                state_nxt = T3;
            end
            T3: begin
                Run = 1'b1;
                // An illegal opcode must not disturb Y or the register bus.
                if (op_legal) begin
                    Grb       = 1'b1;
                    Rout      = 1'b1;
                    Yin       = 1'b1;
                    state_nxt = T4;
                end else begin
                    state_nxt = HALT;
                end
            end
            T4: begin
                Grc       = 1'b1;
                Rout      = 1'b1;
                Zin       = 1'b1;
                ALU_op    = dec_alu_op;
                Run       = 1'b1;
                state_nxt = T5;
            end
            T5: begin
                Zlowout   = 1'b1;
                Gra       = 1'b1;
                Rin       = 1'b1;
                Run       = 1'b1;
                state_nxt = Stop ? HALT : T0;
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = RST;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic        Clock;
    logic        Reset;
    logic [31:0] IR;
    logic        Mem_ready;
    logic        Stop;
    logic        PCout, Zlowout, MDRout;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin;
    logic        IncPC, Read;
    logic        Gra, Grb, Grc;
    logic        Rin, Rout;
    logic [4:0]  ALU_op;
    logic        Run;

    typedef struct packed {
        logic       PCout;
        logic       Zlowout;
        logic       MDRout;
        logic       MARin;
        logic       Zin;
        logic       PCin;
        logic       MDRin;
        logic       IRin;
        logic       Yin;
        logic       IncPC;
        logic       Read;
        logic       Gra;
        logic       Grb;
        logic       Grc;
        logic       Rin;
        logic       Rout;
        logic       Run;
        logic [4:0] ALU_op;
    } strobes_t;

    strobes_t obs;
    int tests_run    = 0;
    int tests_failed = 0;

`ifdef CTRL_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    control_sequencer #(.OPW(5), .RW(4)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .IR        (IR),
        .Mem_ready (Mem_ready),
        .Stop      (Stop),
        .PCout     (PCout),
        .Zlowout   (Zlowout),
        .MDRout    (MDRout),
        .MARin     (MARin),
        .Zin       (Zin),
        .PCin      (PCin),
        .MDRin     (MDRin),
        .IRin      (IRin),
        .Yin       (Yin),
        .IncPC     (IncPC),
        .Read      (Read),
        .Gra       (Gra),
        .Grb       (Grb),
        .Grc       (Grc),
        .Rin       (Rin),
        .Rout      (Rout),
        .ALU_op    (ALU_op),
        .Run       (Run)
    );

    assign obs = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
                  IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run, ALU_op};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    // Step numbering: 0..5 = T0..T5 of one instruction. Anything else = idle.
    function automatic bit legal_op(input logic [4:0] op);
        return (op == 5'd3) || (op == 5'd4) || (op == 5'd9) || (op == 5'd10);
    endfunction

    function automatic strobes_t expect_for(input int step, input logic [31:0] ir, input bit pcin);
        strobes_t e;
        e = '0;
        case (step)
            0: begin e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin = 1; e.Run = 1; end
            1: begin e.Zlowout = 1; e.PCin = pcin; e.Read = 1; e.MDRin = 1; e.Run = 1; end
            2: begin e.MDRout = 1; e.IRin = 1; e.Run = 1; end
            3: begin
                e.Run = 1;
                if (legal_op(ir[31:27])) begin e.Grb = 1; e.Rout = 1; e.Yin = 1; end
            end
            4: begin e.Grc = 1; e.Rout = 1; e.Zin = 1; e.ALU_op = ir[31:27]; e.Run = 1; end
            5: begin e.Zlowout = 1; e.Gra = 1; e.Rin = 1; e.Run = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // Runs one instruction starting from RST (reset released) or from T5.
    // Inputs for a cycle are driven 1 time unit after its opening edge and
    // outputs are checked 2 time units after it.
    task automatic run_instr(input string name, input logic [31:0] ir, input bit stop5,
                             input bit stop2, input bit noise, input int nwait,
                             output bit halted);
        int       steps[$];
        int       t1i[$];
        int       effw;
        bit       legal;
        strobes_t exp;
        effw  = WAIT_EN ? nwait : 0;
        legal = legal_op(ir[31:27]);
        steps.push_back(0); t1i.push_back(0);
        for (int w = 0; w <= effw; w++) begin steps.push_back(1); t1i.push_back(w); end
        steps.push_back(2); t1i.push_back(0);
        steps.push_back(3); t1i.push_back(0);
        if (legal) begin
            steps.push_back(4); t1i.push_back(0);
            steps.push_back(5); t1i.push_back(0);
        end
        halted = !legal || stop5;
        IR = ir;
        for (int i = 0; i < steps.size(); i++) begin
            @(posedge Clock);
            #1;
            if (steps[i] == 1) begin
                if (WAIT_EN) Mem_ready = (t1i[i] == effw);
                else         Mem_ready = (nwait > 0) ? 1'b0 : 1'($urandom_range(0, 1));
            end else begin
                Mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (steps[i] == 5) Stop = stop5;
            else Stop = (steps[i] == 2 && stop2) || (noise && ($urandom_range(0, 1) == 1));
            #1;
            exp = expect_for(steps[i], ir, !WAIT_EN || (t1i[i] == effw));
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL %s T%0d (ir=%h): got %h expected %h", name, steps[i], ir, obs, exp);
            end
        end
    endtask

    task automatic check_halt(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
            Mem_ready = 1'($urandom_range(0, 1));
            Stop      = 1'($urandom_range(0, 1));
            #1;
            tests_run++;
            if (obs !== strobes_t'('0)) begin
                tests_failed++;
                $display("FAIL %s halt cycle %0d: got %h expected 0", name, i, obs);
            end
        end
    endtask

    task automatic do_reset(input string name);
        Reset     = 1'b1;
        Stop      = 1'b0;
        Mem_ready = 1'b1;
        repeat (2) @(posedge Clock);
        #2;
        tests_run++;
        if (obs !== strobes_t'('0)) begin
            tests_failed++;
            $display("FAIL %s reset_hold: got %h expected 0", name, obs);
        end
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset = 1'b1;
        #2;
        tests_run++;
        if (Run !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_run: got %b expected 0", Run);
        end
        do_reset("reset");
    endtask

    task automatic test_directed();
        bit h;
        run_instr("and_r5r2r4", 32'h4A920000, 0, 0, 0, 0, h);
        run_instr("add",        {5'b00011, 27'h2920000}, 0, 0, 0, 0, h);
        run_instr("sub",        {5'b00100, 27'h2920000}, 0, 0, 0, 0, h);
        run_instr("or",         {5'b01010, 27'h2920000}, 0, 0, 0, 0, h);
        run_instr("add_1a92",   32'h1A920000, 0, 0, 0, 0, h);
    endtask

    task automatic test_illegal();
        bit h;
        run_instr("illegal", 32'hF8000000, 0, 0, 0, 0, h);
        check_halt("illegal", 20);
        do_reset("illegal");
        run_instr("after_illegal", 32'h4A920000, 0, 0, 0, 0, h);
    endtask

    task automatic test_stop();
        bit h;
        run_instr("stop_t2", 32'h1A920000, 0, 1, 0, 0, h);
        run_instr("stop_t5", 32'h4A920000, 1, 0, 0, 0, h);
        check_halt("stop_t5", 4);
        do_reset("stop_t5");
        run_instr("after_stop", {5'b00100, 27'h1234567}, 0, 0, 0, 0, h);
    endtask

    task automatic test_reset_mid();
        bit       h;
        strobes_t exp;
        IR        = 32'h4A920000;
        Mem_ready = 1'b1;
        Stop      = 1'b0;
        for (int s = 0; s <= 4; s++) begin
            @(posedge Clock);
            #2;
            exp = expect_for(s, IR, 1'b1);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL reset_mid T%0d: got %h expected %h", s, obs, exp);
            end
        end
        #1;
        Reset = 1'b1;
        #1;
        tests_run++;
        if (obs !== strobes_t'('0)) begin
            tests_failed++;
            $display("FAIL reset_mid async_clear: got %h expected 0", obs);
        end
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        run_instr("after_reset_mid", 32'h4A920000, 0, 0, 0, 0, h);
    endtask

    task automatic test_mem_wait();
        bit h;
        run_instr("mem_wait3", 32'h4A920000, 0, 0, 0, 3, h);
        run_instr("mem_wait1", {5'b01010, 27'h0ABCDEF}, 0, 0, 1, 1, h);
    endtask

    task automatic test_random();
        bit          h;
        logic [4:0]  op;
        logic [31:0] ir;
        logic [4:0]  legal_tab [4];
        legal_tab[0] = 5'd3; legal_tab[1] = 5'd4; legal_tab[2] = 5'd9; legal_tab[3] = 5'd10;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) != 0) op = legal_tab[$urandom_range(0, 3)];
            else                           op = 5'($urandom);
            ir = {op, 27'($urandom)};
            run_instr("random", ir, $urandom_range(0, 9) == 0, 0, 1, $urandom_range(0, 3), h);
            if (h) begin
                check_halt("random", $urandom_range(1, 4));
                do_reset("random");
            end
        end
    endtask

    initial begin
        Reset     = 1'b1;
        IR        = '0;
        Mem_ready = 1'b1;
        Stop      = 1'b0;
        test_reset();
        test_directed();
        test_illegal();
        test_stop();
        test_reset_mid();
        test_mem_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the datapath of the 32-bit processor. It generates the per-step control strobes (T0–T5) that the datapath consumes and performs the instruction fetch, IR decode and ALU register-register execute sequence. The strobe names and their meanings match the datapath's control inputs one for one. The block sits beside the datapath, reads IR back from it, and optionally handshakes with memory during fetch.

## Interface
Parameters:
- OPW, 5, opcode field width, IR[31:27]
- RW, 4, register-select field width

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high
- IR  in  32  instruction register contents from the datapath
- Mem_ready  in  1  memory read data valid; used only with CTRL_MEM_WAIT_EN
- Stop  in  1  halt request, sampled in T5
- PCout, Zlowout, MDRout  out  1 each  bus drive strobes
- MARin, Zin, PCin, MDRin, IRin, Yin  out  1 each  register load strobes
- IncPC, Read  out  1 each  PC increment, memory read
- Gra, Grb, Grc  out  1 each  select IR Ra/Rb/Rc for the select-and-encode logic
- Rin, Rout  out  1 each  general register load/drive, qualified by Gra/Grb/Grc
- ALU_op  out  5  ALU operation code; equals the opcode while Zin is asserted in T4, otherwise 0
- Run  out  1  high while sequencing, low in reset and HALT

## Operation
- States are RST, T0, T1, T2, T3, T4, T5 and HALT. Outputs are Moore-decoded from the registered state and IR.
- The state register and all outputs are 0 during Reset. Run is 0 in RST. The first rising edge after Reset deasserts moves RST to T0.
- The asserted strobes in each state are as follows. Every unlisted strobe is 0.
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, ALU_op=opcode.
  - T5: Zlowout, Gra, Rin.
- Transitions are T0→T1→T2→T3→T4→T5.
- From T5, the block goes to HALT if Stop=1 and to T0 otherwise.
- Legal opcodes are add 00011, sub 00100, and 01001 and or 01010. The opcode is decoded in T3 from the IR value loaded at the end of T2.
- An illegal opcode in T3 sends the block to HALT on the next edge. The T3 strobes are suppressed in that cycle: Rout=0 and Yin=0.
- HALT is absorbing. All strobes are 0 and Run=0 until Reset.
- Field extraction: Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]. The sequencer only asserts Gra/Grb/Grc; register index decoding lies outside the block.

## Timing
- Without wait states, each instruction takes 6 cycles from T0 entry to T5 exit.
- Strobes are valid from just after the rising edge that enters a state until the next rising edge. Loads occur at the edge that ends the state.
- IR is sampled combinationally in T3–T5. The datapath must hold IR stable from the end of T2 until T0.
- Reset mid-instruction clears state and outputs immediately, with no waiting for a clock edge. A partially executed instruction is abandoned, and Rin is never asserted after Reset.
- Stop is ignored outside T5. Stop=1 in T5 still completes that T5 write.

## Configuration
- CTRL_MEM_WAIT_EN defined:
  - T1 holds, with all T1 strobes held, until Mem_ready=1 is sampled. It advances to T2 on that edge.
  - PCin is asserted only in the final T1 cycle so the PC loads exactly once.
  - A Mem_ready pulse outside T1 is ignored.
- CTRL_MEM_WAIT_EN undefined: T1 lasts exactly 1 cycle, and the Mem_ready port is present but unused.

## Structure
- Shared package cpu_pkg holds:
  - the state enum (RST, T0–T5, HALT);
  - the opcode constants OP_ADD, OP_SUB, OP_AND, OP_OR;
  - the IR field bit positions.
- Sub-module ctrl_decode is combinational. It maps IR to a legal flag and ALU_op, and the sequencer instantiates it once.
- The sequencer holds the state register, next-state logic and strobe decode.

## Test plan
- Reset then IR=32'h4A920000 (and R5,R2,R4): the strobe sets for T0–T5 match Operation exactly, ALU_op=01001 in T4 only, and Run=1; the next cycle after T5 is T0.
- IR=32'h1A920000 (opcode 00011, add): identical sequence with ALU_op=00011 in T4. Repeat for sub and or.
- IR=32'hF8000000 (illegal opcode 11111): in T3 no Rout or Yin; the next cycle is HALT with Run=0 and all strobes 0 for 20 cycles; Reset returns the block to T0.
- Stop=1 held during T5: Rin and Gra are asserted in T5, then HALT follows. Stop=1 in T2 only: no effect.
- Reset asserted mid-T4 (not edge-aligned): all outputs drop to 0 within the same cycle. After release, the sequence restarts at T0 with no Rin from the aborted instruction.
- With CTRL_MEM_WAIT_EN, Mem_ready held low 3 cycles then high: T1 lasts 4 cycles, Read and MDRin are high throughout, PCin is high only in the 4th cycle, and T2 follows. An instruction with the stall takes 9 cycles in total.
